// File: rtl/nibble_serial_alu_if.sv
// nibble_serial_alu_if
// Request/response bundle for the digit-serial ALU.
//   master : requester side (CPU control FSM) - drives the request and done_ready
//   slave  : ALU side - drives start_ready, done_valid, result and carry_out
// Request : start_valid/start_ready, cmd[2:0], carry_in, len[LW-1:0], b_signed, a, b
// Response: done_valid/done_ready, result, carry_out
interface nibble_serial_alu_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) ();
    localparam int DIGITS = WORD_WIDTH / DIGIT_WIDTH;
    localparam int LW     = $clog2(DIGITS);

    logic                  start_valid;
    logic                  start_ready;
    logic [2:0]            cmd;
    logic                  carry_in;
    logic [LW-1:0]         len;
    logic                  b_signed;
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic                  done_valid;
    logic                  done_ready;
    logic [WORD_WIDTH-1:0] result;
    logic                  carry_out;

    modport master (
        output start_valid, cmd, carry_in, len, b_signed, a, b, done_ready,
        input  start_ready, done_valid, result, carry_out
    );

    modport slave (
        input  start_valid, cmd, carry_in, len, b_signed, a, b, done_ready,
        output start_ready, done_valid, result, carry_out
    );
endinterface

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu
// Digit-serial ALU: one DIGIT_WIDTH-bit digit of a WORD_WIDTH operand pair per
// cycle. Commands: ADD, SUB, COMP (a-b-1, carry = a>b), EQ, RSHFT.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - nibble_serial_alu_if.slave (request and response handshakes)
// Build option:
//   NIBBLE_SERIAL_ALU_EARLY_EXIT_EN - ADD/SUB/COMP stop as soon as the digits
//   above len can no longer change the result (same result, lower latency).
module nibble_serial_alu #(
    parameter int WORD_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_alu_if.slave bus
);
    localparam int DIGITS = WORD_WIDTH / DIGIT_WIDTH;
    localparam int LW     = $clog2(DIGITS);
    localparam logic [LW-1:0] LAST_IDX = LW'(DIGITS - 1);

    localparam logic [2:0] CMD_ADD   = 3'b000;
    localparam logic [2:0] CMD_SUB   = 3'b001;
    localparam logic [2:0] CMD_COMP  = 3'b010;
    localparam logic [2:0] CMD_EQ    = 3'b011;
    localparam logic [2:0] CMD_RSHFT = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [DIGITS-1:0][DIGIT_WIDTH-1:0] word_t;
    typedef logic [DIGIT_WIDTH-1:0]             digit_t;

    state_t        state_q, state_d;
    word_t         a_q, b_q, res_q;
    logic [2:0]    cmd_q;
    logic [LW-1:0] len_q, idx_q, idx_nxt;
    logic          c_q, cout_q;

    // ---------------- request decode ----------------
    word_t      a_in, b_in, b_ext, b_load;
    logic [2:0] cmd_in;
    logic       fill, c_init, accept;

    assign a_in   = bus.a;
    assign b_in   = bus.b;
    assign cmd_in = (bus.cmd > CMD_RSHFT) ? CMD_ADD : bus.cmd;
    assign fill   = bus.b_signed & b_in[bus.len][DIGIT_WIDTH-1];

    // Digits above len are replaced by the extension fill.
    for (genvar i = 0; i < DIGITS; i++) begin : g_ext
        assign b_ext[i] = (i > int'(bus.len)) ? {DIGIT_WIDTH{fill}} : b_in[i];
    end

    // b_q holds the per-digit second operand: inverted extension for the
    // subtract forms, extension for ADD, raw b for EQ/RSHFT.
    always_comb begin
        case (cmd_in)
            CMD_SUB, CMD_COMP: b_load = ~b_ext;
            CMD_ADD:           b_load = b_ext;
            default:           b_load = b_in;
        endcase
        case (cmd_in)
            CMD_SUB:          c_init = 1'b1;
            CMD_COMP, CMD_EQ: c_init = 1'b0;
            default:          c_init = bus.carry_in;
        endcase
    end

    // ---------------- digit step ----------------
    digit_t               dig_a, dig_b, dig_res;
    logic [DIGIT_WIDTH:0] sum, shr;
    logic                 c_nxt, last, early;

    always_comb begin
        dig_a   = a_q[idx_q];
        dig_b   = b_q[idx_q];
        sum     = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT_WIDTH{1'b0}}, c_q};
        shr     = {c_q, dig_b} >> 1;
        idx_nxt = idx_q + 1'b1;
`ifdef NIBBLE_SERIAL_ALU_EARLY_EXIT_EN
        // Above len every b_eff digit is the same fill, so once the next digit
        // is an identity (0 with no carry, all-ones with carry) all remaining
        // digits are too: result digits stay a, carry stays put.
        early = (idx_q >= len_q) &&
                ((b_q[idx_nxt] == '0 && !sum[DIGIT_WIDTH]) ||
                 (b_q[idx_nxt] == '1 &&  sum[DIGIT_WIDTH]));
`else
        early = 1'b0;
`endif
        dig_res = sum[DIGIT_WIDTH-1:0];
        c_nxt   = sum[DIGIT_WIDTH];
        last    = (idx_q == LAST_IDX) || early;
        case (cmd_q)
            CMD_EQ: begin
                // XNOR digit all-ones is simply digit equality
                dig_res = dig_a;
                c_nxt   = (dig_a == dig_b);
                last    = !c_nxt || (idx_q == len_q);
            end
            CMD_RSHFT: begin
                dig_res = shr[DIGIT_WIDTH-1:0];
                c_nxt   = dig_b[0];
                last    = (idx_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.start_valid) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN:  if (last) state_d = DONE;
            DONE: if (bus.done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.start_ready = (state_q == IDLE);
        bus.done_valid  = (state_q == DONE);
    end

    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cmd_q  <= CMD_ADD;
            len_q  <= '0;
            idx_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a_in;
            b_q   <= b_load;
            cmd_q <= cmd_in;
            len_q <= bus.len;
            c_q   <= c_init;
            // unprocessed digits hold a, or b for a shift
            res_q <= (cmd_in == CMD_RSHFT) ? b_in : a_in;
            idx_q <= (cmd_in == CMD_RSHFT) ? bus.len : '0;
        end else if (state_q == RUN) begin
            res_q[idx_q] <= dig_res;
            c_q          <= c_nxt;
            idx_q        <= (cmd_q == CMD_RSHFT) ? idx_q - 1'b1 : idx_nxt;
            if (last) cout_q <= c_nxt;
        end
    end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb_nibble_serial_alu
// Directed vector table, handshake and reset sequences, then random
// operations checked against an arithmetic reference model.
module tb_nibble_serial_alu;
    localparam int WW = 32;
    localparam int DW = 4;
`ifdef NIBBLE_SERIAL_ALU_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_alu_if #(.WORD_WIDTH(WW), .DIGIT_WIDTH(DW)) bus ();
    nibble_serial_alu #(.WORD_WIDTH(WW), .DIGIT_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic        cin;
        logic [2:0]  len;
        logic        bs;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        int          n;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: whole-word arithmetic on the specification's rules.
    function automatic void model(input logic [2:0] cmd_i, input logic cin, input logic [2:0] len,
                                  input logic bs, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic cout, output int n);
        logic [2:0]  cmd;
        int          w;
        logic [32:0] m33, sum;
        logic [31:0] mask, bext, beff;
        logic        cin0;
        logic [4:0]  s;
        logic [3:0]  nd;
        logic        c;
        cmd  = (cmd_i > 3'd4) ? 3'd0 : cmd_i;
        w    = (int'(len) + 1) * 4;
        m33  = (33'd1 << w) - 33'd1;
        mask = m33[31:0];
        bext = (b & mask) | ((bs && b[w-1]) ? ~mask : 32'd0);
        beff = (cmd == 3'd1 || cmd == 3'd2) ? ~bext : bext;
        cin0 = (cmd == 3'd0) ? cin : (cmd == 3'd1);
        n    = 8;
        res  = a;
        cout = 1'b0;
        case (cmd)
            3'd3: begin
                n    = int'(len) + 1;
                cout = 1'b1;
                for (int i = 0; i <= int'(len); i++) begin
                    if (a[4*i +: 4] != b[4*i +: 4]) begin
                        n    = i + 1;
                        cout = 1'b0;
                        break;
                    end
                end
            end
            3'd4: begin
                res  = (b & ~mask) | ((b & mask) >> 1) | ({31'd0, cin} << (w - 1));
                cout = b[0];
                n    = int'(len) + 1;
            end
            default: begin
                sum  = {1'b0, a} + {1'b0, beff} + {32'd0, cin0};
                res  = sum[31:0];
                cout = sum[32];
                if (EE) begin
                    // latency: digits up to len, then until the rest is an identity
                    c = cin0;
                    for (int i = 0; i < 7; i++) begin
                        s  = {1'b0, a[4*i +: 4]} + {1'b0, beff[4*i +: 4]} + {4'd0, c};
                        c  = s[4];
                        nd = beff[4*(i+1) +: 4];
                        if (i >= int'(len) && ((nd == 4'h0 && !c) || (nd == 4'hF && c))) begin
                            n = i + 1;
                            break;
                        end
                    end
                end
            end
        endcase
    endfunction

    task automatic start_req(input logic [2:0] cmd, input logic cin, input logic [2:0] len,
                             input logic bs, input logic [31:0] a, input logic [31:0] b);
        bus.cmd         = cmd;
        bus.carry_in    = cin;
        bus.len         = len;
        bus.b_signed    = bs;
        bus.a           = a;
        bus.b           = b;
        bus.start_valid = 1'b1;
    endtask

    // Called at the negedge just after the accept edge.
    task automatic wait_done(output logic [31:0] res, output logic cout, output int n);
        bus.start_valid = 1'b0;
        n = 0;
        while (!bus.done_valid && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!bus.done_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done timeout: got done_valid 0, expected 1 within 64 cycles");
        end
        res  = bus.result;
        cout = bus.carry_out;
    endtask

    task automatic do_op(input logic [2:0] cmd, input logic cin, input logic [2:0] len,
                         input logic bs, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic cout, output int n);
        start_req(cmd, cin, len, bs, a, b);
        @(posedge clk);
        @(negedge clk);
        wait_done(res, cout, n);
    endtask

    task automatic release_done();
        bus.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.done_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [31:0] r, er, a, b;
        logic        co, eco, seen;
        int          n, en, d;
        logic [2:0]  cmd, len;
        logic        cin, bs;

        //          cmd   cin   len   bs    a             b             res           cout  n
        vt[0]  = '{3'd0, 1'b0, 3'd0, 1'b0, 32'h00FF0004, 32'h00000004, 32'h00FF0008, 1'b0, EE ? 1 : 8};
        vt[1]  = '{3'd0, 1'b0, 3'd3, 1'b1, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0000FFFE, 1'b1, EE ? 4 : 8};
        vt[2]  = '{3'd2, 1'b0, 3'd7, 1'b0, 32'h12341234, 32'h12341233, 32'h00000000, 1'b1, 8};
        vt[3]  = '{3'd2, 1'b0, 3'd7, 1'b0, 32'h12341234, 32'h12341234, 32'hFFFFFFFF, 1'b0, 8};
        vt[4]  = '{3'd1, 1'b0, 3'd7, 1'b0, 32'h00001000, 32'h00000500, 32'h00000B00, 1'b1, 8};
        vt[5]  = '{3'd3, 1'b0, 3'd7, 1'b0, 32'h12341234, 32'h12341234, 32'h12341234, 1'b1, 8};
        vt[6]  = '{3'd3, 1'b0, 3'd7, 1'b0, 32'h12341134, 32'h12341234, 32'h12341134, 1'b0, 3};
        vt[7]  = '{3'd4, 1'b1, 3'd7, 1'b0, 32'h00000000, 32'h06000000, 32'h83000000, 1'b0, 8};
        vt[8]  = '{3'd4, 1'b0, 3'd7, 1'b0, 32'h00000000, 32'h06000000, 32'h03000000, 1'b0, 8};
        vt[9]  = '{3'd4, 1'b1, 3'd0, 1'b0, 32'h00000000, 32'hABCDEF13, 32'hABCDEF19, 1'b1, 1};
        vt[10] = '{3'd3, 1'b0, 3'd0, 1'b0, 32'h00000005, 32'hFFFFFFF5, 32'h00000005, 1'b1, 1};
        vt[11] = '{3'd0, 1'b1, 3'd7, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 8};
        vt[12] = '{3'd1, 1'b0, 3'd1, 1'b0, 32'h00000100, 32'hFFFFFF01, 32'h000000FF, 1'b1, EE ? 3 : 8};

        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        bus.cmd         = 3'd0;
        bus.carry_in    = 1'b0;
        bus.len         = 3'd0;
        bus.b_signed    = 1'b0;
        bus.a           = 32'd0;
        bus.b           = 32'd0;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("reset done_valid",  {31'd0, bus.done_valid},  32'd0);
        check("reset result",      bus.result,               32'd0);
        check("reset carry_out",   {31'd0, bus.carry_out},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors
        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].cmd, vt[i].cin, vt[i].len, vt[i].bs, vt[i].a, vt[i].b, r, co, n);
            check($sformatf("vec%0d result", i),    r,               vt[i].res);
            check($sformatf("vec%0d carry_out", i), {31'd0, co},     {31'd0, vt[i].cout});
            check($sformatf("vec%0d latency", i),   n,               vt[i].n);
            release_done();
            check($sformatf("vec%0d start_ready after handshake", i), {31'd0, bus.start_ready}, 32'd1);
        end

        // done held off for 5 cycles while a second request waits
        do_op(3'd1, 1'b0, 3'd7, 1'b0, 32'h00001000, 32'h00000500, r, co, n);
        start_req(3'd0, 1'b0, 3'd7, 1'b0, 32'h00000001, 32'h00000002);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold done_valid",  {31'd0, bus.done_valid},  32'd1);
            check("hold result",      bus.result,               32'h00000B00);
            check("hold carry_out",   {31'd0, bus.carry_out},   32'd1);
            check("hold start_ready", {31'd0, bus.start_ready}, 32'd0);
        end
        release_done();
        check("post handshake done_valid",  {31'd0, bus.done_valid},  32'd0);
        check("post handshake start_ready", {31'd0, bus.start_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("queued request accepted", {31'd0, bus.start_ready}, 32'd0);
        wait_done(r, co, n);
        check("queued result",  r, 32'h00000003);
        check("queued latency", n, 8);
        release_done();

        // reset in the 3rd RUN cycle
        start_req(3'd4, 1'b1, 3'd7, 1'b0, 32'h00000000, 32'h06000000);
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid-run rst start_ready", {31'd0, bus.start_ready}, 32'd1);
        check("mid-run rst done_valid",  {31'd0, bus.done_valid},  32'd0);
        check("mid-run rst result",      bus.result,               32'd0);
        check("mid-run rst carry_out",   {31'd0, bus.carry_out},   32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_valid) seen = 1'b1;
        end
        check("no done after rst", {31'd0, seen}, 32'd0);

        // random operations against the model
        for (int k = 0; k < 300; k++) begin
            cmd = 3'($urandom_range(0, 7));
            len = 3'($urandom_range(0, 7));
            cin = 1'($urandom_range(0, 1));
            bs  = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                b = a;
                d = int'($urandom_range(0, 9));
                if (d < 8) b[4*d +: 4] = b[4*d +: 4] ^ 4'($urandom_range(1, 15));
            end
            model(cmd, cin, len, bs, a, b, er, eco, en);
            do_op(cmd, cin, len, bs, a, b, r, co, n);
            check($sformatf("rand%0d cmd%0d result", k, cmd),    r,           er);
            check($sformatf("rand%0d cmd%0d carry_out", k, cmd), {31'd0, co}, {31'd0, eco});
            check($sformatf("rand%0d cmd%0d latency", k, cmd),   n,           en);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Digit-serial ALU sequencer, the parametrised successor of the 32-bit nibble loop: it processes a WORD_WIDTH operand pair one DIGIT_WIDTH-bit digit per cycle. It supports add, subtract, compare, equality and right-shift, with signed operand-length extension and a valid/ready request/response handshake. It sits between the CPU control FSM and the register file and replaces the unhandshaked loop.

## Interface
- WORD_WIDTH, 32, operand/result width; WORD_WIDTH/DIGIT_WIDTH must be a power of two ≥ 2
- DIGIT_WIDTH, 4, bits per digit processed per cycle
- DIGITS (localparam), WORD_WIDTH/DIGIT_WIDTH; LW = $clog2(DIGITS)
- One clock; reset is synchronous and active-high (clk, rst)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start_valid  in  1  request present
- start_ready  out  1  high only in IDLE
- cmd  in  3  000 ADD, 001 SUB, 010 COMP, 011 EQ, 100 RSHFT; others treated as ADD
- carry_in  in  1  ADD carry-in, or RSHFT bit shifted into the top of digit len
- len  in  LW  index of the operand's most significant digit (operand length − 1)
- b_signed  in  1  sign-extend b above digit len from b[len*DIGIT_WIDTH+DIGIT_WIDTH−1]
- a, b  in  WORD_WIDTH  operands, captured on accept
- done_valid  out  1  result available
- done_ready  in  1  consumer accepts result
- result  out  WORD_WIDTH  registered result
- carry_out  out  1  final carry / compare / equality flag

## Operation
- States: IDLE → RUN on start_valid&&start_ready. The accept edge latches a, b, cmd, carry_in, len and b_signed. RUN → DONE after the last digit. DONE → IDLE on done_valid&&done_ready. IDLE never takes a new request in the same cycle as the DONE handshake.
- Effective b: b_ext = b with digits above len replaced by all-zeros, or all-ones when b_signed and the sign bit is set. b_eff = ~b_ext for SUB and COMP, b_ext otherwise.
- Initial carry per command:
  - ADD: carry_in.
  - SUB: forced 1, giving a−b.
  - COMP: forced 0, giving a−b−1.
- ADD/SUB/COMP digit step, ascending from digit 0: result[i] = a[i] + b_eff[i] + c, c ← digit carry.
  - carry_out = final c.
  - COMP: carry_out=1 iff a>b unsigned over the effective width; result = a−b−1.
- EQ: ascending from digit 0, digit = a[i] XNOR b[i].
  - Stops after the first digit that is not all-ones (carry_out=0), or after digit len (carry_out=1).
  - result = a.
- RSHFT: descending from digit len to digit 0.
  - result[i] = {c, b[i][DIGIT_WIDTH−1:1]}, c ← b[i][0], with initial c = carry_in.
  - Digits above len copy b. carry_out = b[0].
- Digits not processed hold a, except RSHFT, where they hold b.
- rst in any state: state IDLE, done_valid=0, result=0, carry_out=0. An in-flight operation is discarded and no done_valid is produced.

## Timing
- After reset: start_ready=1, done_valid=0, result=0, carry_out=0.
- RUN lasts N cycles, one digit per cycle. done_valid rises on the edge ending the last RUN cycle, so done_valid is first seen N cycles after the accept edge.
- N by command:
  - ADD/SUB/COMP: DIGITS (see Configuration).
  - EQ: first mismatching digit index + 1, or len+1.
  - RSHFT: len+1.
- result and carry_out are stable for the whole time done_valid is high. done_valid may stay high indefinitely while done_ready=0.
- start_ready falls on the accept edge and rises the cycle after the DONE handshake.

## Configuration
- NIBBLE_SERIAL_ALU_EARLY_EXIT_EN defined: for ADD/SUB/COMP, each digit i>len is checked before it is processed. RUN ends without processing it when the identity condition holds: (b_eff[i]==0 && c==0) or (b_eff[i]==all-ones && c==1). carry_out = c at exit.
  - N = len+1 + number of extra digits processed.
  - result and carry_out are identical to the non-EARLY_EXIT build; only latency differs.
- Not defined: ADD/SUB/COMP always process all DIGITS digits, N=DIGITS. EQ and RSHFT behave the same in both builds.

## Test plan
All cases use the defaults WORD_WIDTH=32, DIGIT_WIDTH=4.
- ADD a=0x00FF0004 b=4 len=0 carry_in=0 → result 0x00FF0008, carry_out 0; N=1 with EARLY_EXIT, 8 without.
- ADD a=0x0000FFFF b=0xFFFFFFFF len=3 b_signed=1 → result 0x0000FFFE, carry_out 1; N=4 with EARLY_EXIT.
- COMP a=0x12341234 b=0x12341233 → carry_out 1, result 0; with a=b=0x12341234 → carry_out 0, result 0xFFFFFFFF. SUB a=0x1000 b=0x500 → 0x00000B00.
- EQ len=7: a=b=0x12341234 → carry_out 1, N=8; a=0x12341134 b=0x12341234 → carry_out 0, N=3.
- RSHFT b=0x06000000 len=7 carry_in=1 → result 0x83000000, carry_out 0, N=8; with carry_in=0 → 0x03000000.
- Handshake: hold done_ready=0 for 5 cycles → done_valid, result and carry_out stay constant; start_valid held high is not accepted until the cycle after the handshake. Separately, rst asserted in the 3rd RUN cycle → next cycle start_ready=1, done_valid=0, result=0.
